// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller with a small return-address stack.
//
// It selects the next program counter each cycle. The choices are increment, absolute
// jump, signed relative branch (conditional or unconditional), call and return. It also
// runs an IDLE/RUN/HALT control FSM.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   start       leave IDLE and begin execution
//   stall       freeze PC, state, stack and error flag while in RUN
//   halt_req    enter HALT from RUN (PC holds that cycle)
//   resume      leave HALT back to RUN (PC holds that cycle)
//   jump_abs    PC <= target
//   branch_rel  PC <= PC + sext(offset) when taken
//   branch_cond gate the relative branch on cond_flag
//   cond_flag   ALU condition flag
//   call        push PC+1, PC <= target
//   ret         pop return address into PC
//   target      absolute jump/call address
//   offset      two's complement branch displacement
//   prog_ctr    current program counter
//   running     high while in RUN
//   stk_depth   stack occupancy, 0..DEPTH
//   stk_err     sticky overflow/underflow flag, cleared only by reset
module pc_sequencer #(
    parameter int unsigned D     = 12,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned OW    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stall,
    input  logic                       halt_req,
    input  logic                       resume,
    input  logic                       jump_abs,
    input  logic                       branch_rel,
    input  logic                       branch_cond,
    input  logic                       cond_flag,
    input  logic                       call,
    input  logic                       ret,
    input  logic [D-1:0]               target,
    input  logic [OW-1:0]              offset,
    output logic [D-1:0]               prog_ctr,
    output logic                       running,
    output logic [$clog2(DEPTH):0]     stk_depth,
    output logic                       stk_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned SW = AW + 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StHalt = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic [SW-1:0] depth_q, depth_d;
    logic          err_q, err_d;
    logic [D-1:0]  stk_q [DEPTH];

    logic          push;
    logic [D-1:0]  pc_inc;
    logic [D-1:0]  off_ext;
    logic [SW-1:0] top_idx;
    logic          stk_empty;
    logic          stk_full;
    logic          br_taken;

    assign pc_inc    = pc_q + D'(1);
    assign off_ext   = D'($signed(offset));
    assign top_idx   = depth_q - SW'(1);
    assign stk_empty = (depth_q == '0);
    assign stk_full  = (depth_q == SW'(DEPTH));
    assign br_taken  = branch_rel & (~branch_cond | cond_flag);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        err_d   = err_q;
        push    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) state_d = StRun;
            end
            StRun: begin
                if (!stall) begin
                    if (halt_req) begin
                        state_d = StHalt;
                    end else if (ret) begin
                        if (stk_empty) begin
                            err_d = 1'b1;
                            pc_d  = pc_inc;
                        end else begin
                            pc_d    = stk_q[top_idx[AW-1:0]];
                            depth_d = top_idx;
                        end
                    end else if (call) begin
                        pc_d = target;
                        if (stk_full) begin
                            err_d = 1'b1;
                        end else begin
                            push    = 1'b1;
                            depth_d = depth_q + SW'(1);
                        end
                    end else if (jump_abs) begin
                        pc_d = target;
                    end else if (br_taken) begin
                        pc_d = pc_q + off_ext;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            StHalt: begin
                if (resume) state_d = StRun;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Stack storage needs no reset: entries are only read below depth_q.
    always_ff @(posedge clk) begin
        if (push) stk_q[depth_q[AW-1:0]] <= pc_inc;
    end

    assign prog_ctr  = pc_q;
    assign running   = (state_q == StRun);
    assign stk_depth = depth_q;
    assign stk_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer (D=12, DEPTH=4, OW=8).
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        start, stall, halt_req, resume;
    logic        jump_abs, branch_rel, branch_cond, cond_flag, call, ret;
    logic [11:0] target;
    logic [7:0]  offset;
    logic [11:0] prog_ctr;
    logic        running;
    logic [2:0]  stk_depth;
    logic        stk_err;

    int n_vec;
    int n_err;

    pc_sequencer #(.D(12), .DEPTH(4), .OW(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stall       (stall),
        .halt_req    (halt_req),
        .resume      (resume),
        .jump_abs    (jump_abs),
        .branch_rel  (branch_rel),
        .branch_cond (branch_cond),
        .cond_flag   (cond_flag),
        .call        (call),
        .ret         (ret),
        .target      (target),
        .offset      (offset),
        .prog_ctr    (prog_ctr),
        .running     (running),
        .stk_depth   (stk_depth),
        .stk_err     (stk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_ctl();
        start = 0; stall = 0; halt_req = 0; resume = 0; jump_abs = 0; branch_rel = 0;
        branch_cond = 0; cond_flag = 0; call = 0; ret = 0; target = '0; offset = '0;
    endtask

    // One clock: outputs settle #1 after the edge, then controls drop.
    task automatic cycle();
        @(posedge clk);
        #1;
        clear_ctl();
    endtask

    task automatic goto_pc(input logic [11:0] a);
        jump_abs = 1; target = a;
        cycle();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        clear_ctl();
        reset = 0;
        #12;
        check_val("rst_pc", 32'(prog_ctr), 32'h0);
        check_val("rst_run", 32'(running), 32'h0);
        check_val("rst_depth", 32'(stk_depth), 32'h0);
        check_val("rst_err", 32'(stk_err), 32'h0);
        reset = 1;

        // IDLE ignores control inputs
        jump_abs = 1; target = 12'h3AB;
        cycle();
        check_val("idle_hold", 32'(prog_ctr), 32'h0);

        start = 1;
        cycle();
        check_val("start_pc", 32'(prog_ctr), 32'h0);
        check_val("start_run", 32'(running), 32'h1);
        for (int i = 1; i <= 5; i++) begin
            cycle();
            check_val("inc_pc", 32'(prog_ctr), 32'(i));
            check_val("inc_run", 32'(running), 32'h1);
        end

        // Asynchronous reset mid-clock
        #2 reset = 0;
        #1;
        check_val("async_pc", 32'(prog_ctr), 32'h0);
        check_val("async_run", 32'(running), 32'h0);
        #1 reset = 1;
        start = 1;
        cycle();

        // Call / increments / return
        goto_pc(12'h010);
        check_val("goto10", 32'(prog_ctr), 32'h010);
        call = 1; target = 12'h100;
        cycle();
        check_val("call_pc", 32'(prog_ctr), 32'h100);
        check_val("call_depth", 32'(stk_depth), 32'h1);
        for (int i = 1; i <= 3; i++) begin
            cycle();
            check_val("sub_inc", 32'(prog_ctr), 32'h100 + 32'(i));
        end
        ret = 1;
        cycle();
        check_val("ret_pc", 32'(prog_ctr), 32'h011);
        check_val("ret_depth", 32'(stk_depth), 32'h0);

        // Relative branches
        goto_pc(12'h020);
        branch_rel = 1; offset = 8'hFC;
        cycle();
        check_val("br_back", 32'(prog_ctr), 32'h01C);
        branch_rel = 1; branch_cond = 1; cond_flag = 0; offset = 8'h08;
        cycle();
        check_val("br_untaken", 32'(prog_ctr), 32'h01D);
        branch_rel = 1; branch_cond = 1; cond_flag = 1; offset = 8'h08;
        cycle();
        check_val("br_taken", 32'(prog_ctr), 32'h025);

        // Nested calls past DEPTH
        call = 1; target = 12'h200; cycle();
        call = 1; target = 12'h300; cycle();
        call = 1; target = 12'h400; cycle();
        call = 1; target = 12'h500; cycle();
        check_val("call4_depth", 32'(stk_depth), 32'h4);
        check_val("call4_err", 32'(stk_err), 32'h0);
        call = 1; target = 12'h600; cycle();
        check_val("ovf_pc", 32'(prog_ctr), 32'h600);
        check_val("ovf_depth", 32'(stk_depth), 32'h4);
        check_val("ovf_err", 32'(stk_err), 32'h1);
        ret = 1; cycle(); check_val("pop1", 32'(prog_ctr), 32'h401);
        ret = 1; cycle(); check_val("pop2", 32'(prog_ctr), 32'h301);
        ret = 1; cycle(); check_val("pop3", 32'(prog_ctr), 32'h201);
        ret = 1; cycle(); check_val("pop4", 32'(prog_ctr), 32'h026);
        check_val("pop4_depth", 32'(stk_depth), 32'h0);
        ret = 1; cycle();
        check_val("unf_pc", 32'(prog_ctr), 32'h027);
        check_val("unf_err", 32'(stk_err), 32'h1);
        check_val("unf_depth", 32'(stk_depth), 32'h0);

        // Priority: ret beats call and jump_abs
        call = 1; target = 12'h700; cycle();
        check_val("pri_setup", 32'(stk_depth), 32'h1);
        ret = 1; call = 1; jump_abs = 1; target = 12'h123;
        cycle();
        check_val("pri_pc", 32'(prog_ctr), 32'h028);
        check_val("pri_depth", 32'(stk_depth), 32'h0);

        // Stall freezes PC
        stall = 1; jump_abs = 1; target = 12'h555;
        cycle();
        check_val("stall_pc", 32'(prog_ctr), 32'h028);
        stall = 1; halt_req = 1;
        cycle();
        check_val("stall_halt", 32'(running), 32'h1);

        // Wraparound
        goto_pc(12'hFFF);
        cycle();
        check_val("wrap_inc", 32'(prog_ctr), 32'h000);
        goto_pc(12'h002);
        branch_rel = 1; offset = 8'hFD;
        cycle();
        check_val("wrap_br", 32'(prog_ctr), 32'hFFF);

        // Halt / resume
        goto_pc(12'h050);
        halt_req = 1; jump_abs = 1; target = 12'h0AA;
        cycle();
        check_val("halt_pc0", 32'(prog_ctr), 32'h050);
        check_val("halt_run", 32'(running), 32'h0);
        for (int i = 0; i < 2; i++) begin
            jump_abs = 1; target = 12'h0BB;
            cycle();
            check_val("halt_hold", 32'(prog_ctr), 32'h050);
        end
        resume = 1;
        cycle();
        check_val("resume_pc", 32'(prog_ctr), 32'h050);
        check_val("resume_run", 32'(running), 32'h1);
        cycle();
        check_val("resume_inc", 32'(prog_ctr), 32'h051);

        // Reset clears the sticky error
        #2 reset = 0;
        #1;
        check_val("rst2_err", 32'(stk_err), 32'h0);
        check_val("rst2_pc", 32'(prog_ctr), 32'h0);
        reset = 1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller that owns and sequences the program counter.
- Selects each cycle between increment, absolute jump, signed relative branch (conditional or unconditional), subroutine call and return.
- Keeps a small hardware return-address stack and run/halt control.
- Sits between the decoder/ALU flag outputs and instruction memory address; prog_ctr drives the instruction ROM.

Parameters:
D, 12, program counter / address width
DEPTH, 4, return-stack entries (power of 2, 2..16)
OW, 8, relative branch offset width (two's complement)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous active-low reset
start  input  1  pulse; leaves IDLE and begins execution
stall  input  1  hold PC, state and stack this cycle
halt_req  input  1  request halt (decoded halt instruction)
resume  input  1  leave HALT and continue
jump_abs  input  1  absolute jump to target
branch_rel  input  1  relative branch by offset
branch_cond  input  1  1 = relative branch conditional on cond_flag
cond_flag  input  1  ALU condition flag
call  input  1  push return address, jump to target
ret  input  1  pop return address into PC
target  input  D  absolute jump/call address
offset  input  OW  signed relative displacement
prog_ctr  output  D  current program counter
running  output  1  1 when state is RUN
stk_depth  output  $clog2(DEPTH)+1  current stack occupancy
stk_err  output  1  sticky stack overflow/underflow flag

Behaviour:
- Reset (reset=0, async): prog_ctr=0, state=IDLE, stack empty, stk_depth=0, stk_err=0, running=0. Reset mid-operation discards stack contents and any pending halt.
- States:
  - IDLE: PC holds; start=1 -> RUN. No PC change on the start cycle. All control inputs ignored.
  - RUN: PC advances per priority below. halt_req=1 -> HALT; PC holds that cycle and control ops are ignored.
  - HALT: PC and stack hold; resume=1 -> RUN. No PC change on the resume cycle.
- Stall: stall=1 in RUN freezes PC, stack, stk_err and state. halt_req is also ignored while stalled. Stall has no effect in IDLE/HALT.
- RUN next-PC priority, highest first, when not stalled and halt_req=0:
  1. ret: stack non-empty -> PC = top, pop. Stack empty -> stk_err=1, PC = PC+1.
  2. call: stack not full -> push PC+1, PC = target. Stack full -> stk_err=1, no push, PC = target.
  3. jump_abs: PC = target.
  4. branch_rel taken, where taken = branch_rel & (~branch_cond | cond_flag): PC = PC + sign-extended offset.
  5. Otherwise, including an untaken branch: PC = PC+1.
- Only the highest asserted op acts; lower ops in the same cycle are discarded.
- Arithmetic is modulo 2^D. PC = 2^D-1 increments to 0. Relative branches wrap both directions (PC=2, offset=-3 -> 2^D-1). The pushed return address PC+1 wraps likewise.
- Latency: a control input sampled at edge N sets prog_ctr visible after edge N; one-cycle next-PC, no delay slots.
- Stack is LIFO. stk_depth ranges 0..DEPTH and updates in the same edge as the push/pop.
- stk_err is sticky; it clears only on reset.

Test Plan:
- Reset, start, 5 idle cycles -> prog_ctr 0,1,2,3,4,5 with running=1. Assert reset=0 asynchronously mid-clock -> prog_ctr=0 immediately, running=0.
- At PC=0x010: call target=0x100, then 3 increments, then ret -> PC 0x100,0x101,0x102,0x103,0x011; stk_depth 1 then 0.
- At PC=0x020: branch_rel offset=-4 unconditional -> 0x01C. branch_cond=1, cond_flag=0, offset=+8 -> 0x01D. cond_flag=1 -> 0x025.
- Five nested calls with DEPTH=4 -> 5th call jumps to its target but stk_depth stays 4 and stk_err=1. Then 5 rets -> 4 pops return in LIFO order; 5th ret increments PC; stk_err stays 1.
- Simultaneous ret+call+jump_abs with stack depth 1 -> only ret acts (PC=popped value, depth 0). stall=1 with jump_abs=1 -> PC unchanged.
- PC=0xFFF increment -> 0x000. halt_req at PC=0x050 -> PC holds 0x050 through 3 cycles, running=0. resume -> PC holds on that cycle, then 0x051.
